// File: rtl/data_ram_block_reader.sv
// Avalon-MM pipelined read master that fetches a block of consecutive words and
// streams them out in order on a valid/ready port, buffered by a small credit-guarded FIFO.
module data_ram_block_reader #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  busy,
    output logic                  done,

    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic                  avm_readdatavalid,
    input  logic [DATA_WIDTH-1:0] avm_readdata,

    output logic                  src_valid,
    output logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_last,
    input  logic                  src_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  delivered;
    logic [CNT_W-1:0]      pending;
    logic [CNT_W-1:0]      fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  last_pop;
    logic [CNT_W-1:0]      pending_next;
    logic [CNT_W-1:0]      count_next;
    logic [LEN_WIDTH-1:0]  remaining_next;
    logic [CNT_W:0]        used_next;
    logic                  credit_ok;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign src_valid = (fifo_count != '0);
    assign src_data  = src_valid ? fifo_mem[rd_ptr] : '0;
    assign src_last  = src_valid && (delivered == (len_q - LEN_WIDTH'(1)));

    // Returns with nothing outstanding (e.g. stragglers from before a reset) are dropped,
    // so a push can never find the FIFO without a reserved slot.
    always_comb begin
        accept         = avm_read & ~avm_waitrequest;
        push           = avm_readdatavalid & (pending != '0);
        pop            = src_valid & src_ready;
        last_pop       = pop & src_last;
        pending_next   = pending + CNT_W'(accept) - CNT_W'(push);
        count_next     = fifo_count + CNT_W'(push) - CNT_W'(pop);
        remaining_next = remaining - LEN_WIDTH'(accept);
        used_next      = {1'b0, pending_next} + {1'b0, count_next};
        credit_ok      = (used_next < DEPTH_SUM);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= avm_readdata;
        end
    end

    // A raised read holds its address and its credit until the slave takes it;
    // a new read is only raised when one more word still fits in the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_address <= '0;
            done        <= 1'b0;
            len_q       <= '0;
            remaining   <= '0;
            delivered   <= '0;
            pending     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            done       <= 1'b0;
            pending    <= pending_next;
            fifo_count <= count_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                delivered <= delivered + LEN_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            len_q       <= cmd_len;
                            remaining   <= cmd_len;
                            delivered   <= '0;
                            avm_address <= cmd_addr;
                            avm_read    <= 1'b1;
                            state       <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (accept) begin
                        avm_address <= avm_address + ADDR_WIDTH'(1);
                        remaining   <= remaining_next;
                        if (remaining_next == '0) begin
                            avm_read <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            avm_read <= credit_ok;
                        end
                    end else if (!avm_read) begin
                        avm_read <= credit_ok;
                    end
                end

                DRAIN: begin
                    if (last_pop) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_ram_block_reader.md
# data_ram_block_reader

Avalon-MM read master that fetches a block of consecutive 32-bit words from the controller's on-chip data RAM, or any Avalon-MM slave with pipelined reads, and delivers them in order on a valid/ready stream. It is the initiating end of the data RAM's slave port: it lets hardware consumers such as telemetry packers and parameter loaders pull RAM contents without the CPU. A small internal FIFO and a credit counter guarantee that sink backpressure never causes read data to be lost.

## Interface
- ADDR_WIDTH, 11, word-address width; addresses wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 32, word width.
- LEN_WIDTH, 12, width of the word-count field.
- FIFO_DEPTH, 4, output FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  LEN_WIDTH  word count; 0 = no-op.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- avm_address  out  ADDR_WIDTH  word address.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdatavalid  in  1  read data strobe.
- avm_readdata  in  DATA_WIDTH  read data.
- src_valid  out  1  stream data valid.
- src_data  out  DATA_WIDTH  stream data.
- src_last  out  1  marks final word of the block.
- src_ready  in  1  sink accept.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid with len=0: done pulses next cycle; state stays IDLE; no bus activity.
  - On cmd_valid with len>0: latch addr/len; go to ISSUE.
- **ISSUE**
  - Credits: pending reads + FIFO occupancy ≤ FIFO_DEPTH at all times.
  - avm_read rises only when credits remain.
  - Once raised, avm_read, avm_address and the credit reservation hold until the cycle avm_read & !avm_waitrequest (accept).
  - On accept: address+1 (wrapping), remaining−1, pending+1.
  - After the final accept: avm_read=0; go to DRAIN.
- **Read data return**
  - avm_readdatavalid with pending>0 writes avm_readdata into the FIFO and decrements pending.
  - avm_readdatavalid with pending=0 is ignored.
- **Stream output**
  - The FIFO head drives src_data/src_valid; a word pops on src_valid & src_ready.
  - src_last=1 with the word whose index is len−1; tracked by a delivered-word counter.
- **DRAIN**
  - Leave when the last word has been popped; done pulses the following cycle; go to IDLE.
- **Simultaneous events**
  - Issue, return and pop in the same cycle update pending and FIFO count net-correctly.
  - FIFO push and pop in the same cycle are legal when the FIFO is full.
- **Reset** (any state): returns to IDLE, empties the FIFO and zeroes pending; returns for pre-reset reads are then dropped.
- **Reset values:** cmd_ready=1, busy=0, done=0, avm_read=0, avm_address=0, src_valid=0, src_last=0, src_data=0.

## Timing
- Command accepted in cycle N (cmd_valid & cmd_ready): avm_read=1 with cmd_addr in N+1.
- With a latency-1 slave, waitrequest=0 and src_ready=1:
  - readdatavalid arrives in N+2.
  - First src_valid in N+3 (registered FIFO).
- Sustained throughput is 1 word/cycle when FIFO_DEPTH≥4 and src_ready stays high.
- done is asserted in the cycle after the src_last handshake. cmd_ready returns that same cycle.
- busy falls in the same cycle done pulses.

## Test plan
- RAM words 0x010–0x013 = 0xA0–0xA3; cmd addr 0x010 len 4; latency-1 slave; src_ready=1 -> avm_address 0x010–0x013 on consecutive cycles; src_data A0–A3 on 4 consecutive cycles; src_last with A3; done one cycle later.
- cmd addr 0x7FE len 4 -> avm_address 0x7FE, 0x7FF, 0x000, 0x001; data returned in that order.
- len 10 with src_ready=0 -> avm_read stops after 4 accepts (FIFO_DEPTH); release src_ready -> all 10 words arrive in order with no loss or duplication; src_last on the 10th.
- avm_waitrequest held 3 cycles on the 2nd read -> avm_read and avm_address stable for 4 cycles; exactly one accept; correct data order.
- cmd len 0 -> avm_read never asserts; done pulses one cycle after accept; busy stays 0.
- reset asserted mid-ISSUE with 2 reads pending -> all outputs at reset values next cycle; late readdatavalid ignored (src_valid stays 0); new cmd addr 0x020 len 2 completes correctly.
